// File: rtl/dram_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dram_fifo_pkg
// Purpose  : Shared sizing helpers and grant encoding for the RAM-backed FIFO.
// Revision : 1.0
// ============================================================================
package dram_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 5;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    // Level counts RAM entries plus the output register, so it needs one extra bit.
    function automatic int level_width(input int aw);
        return aw + 1;
    endfunction

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } gnt_e;

endpackage : dram_fifo_pkg
`default_nettype wire

// File: rtl/dram_fifo_arb.sv
`default_nettype none
// ============================================================================
// Module   : dram_fifo_arb
// Purpose  : Per-cycle write/prefetch arbitration for the single RAM port.
// Revision : 1.0
// ============================================================================
module dram_fifo_arb
    import dram_fifo_pkg::*;
(
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic flush_i,
    input  logic wr_valid_i,
    input  logic full_i,
    input  logic ram_nonempty_i,
    input  logic rd_valid_i,
    input  logic rd_ready_i,
    output gnt_e grant_o,
    output logic wr_ready_o
);

    logic prio_rd_q;
    logic prio_rd_d;
    logic want_wr;
    logic want_rd;

    always_comb begin
        want_wr   = wr_valid_i && !full_i;
        want_rd   = ram_nonempty_i && (!rd_valid_i || rd_ready_i);
        grant_o   = GNT_NONE;
        prio_rd_d = prio_rd_q;
        if (flush_i) begin
            prio_rd_d = 1'b0;
        end else if (want_wr && want_rd) begin
            // Round-robin only advances when both sides actually compete.
            grant_o   = prio_rd_q ? GNT_RD : GNT_WR;
            prio_rd_d = !prio_rd_q;
        end else if (want_wr) begin
            grant_o = GNT_WR;
        end else if (want_rd) begin
            grant_o = GNT_RD;
        end
    end

    assign wr_ready_o = !flush_i && !full_i && !(want_rd && prio_rd_q);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prio_rd_q <= 1'b0;
        end else begin
            prio_rd_q <= prio_rd_d;
        end
    end

endmodule : dram_fifo_arb
`default_nettype wire

// File: rtl/dram_fifo_sched.sv
`default_nettype none
// ============================================================================
// Module   : dram_fifo_sched
// Purpose  : Turns an external single-port async-read RAM into a FIFO with a
//            registered output stage and valid/ready handshakes.
// Revision : 1.0
// ============================================================================
module dram_fifo_sched
    import dram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_din_o,
    output logic                  ram_we_o,
    input  logic [DATA_WIDTH-1:0] ram_dout_i,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int                DEPTH     = fifo_depth(ADDR_WIDTH);
    localparam int                LVL_W     = level_width(ADDR_WIDTH);
    localparam logic [LVL_W-1:0]  DEPTH_CNT = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  CNT_ONE   = LVL_W'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q,    wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q,    rd_ptr_d;
    logic [LVL_W-1:0]      ram_count_q, ram_count_d;
    logic                  rd_valid_q,  rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q,   rd_data_d;

    gnt_e grant;
    logic grant_wr;
    logic grant_rd;
    logic full;

    assign full = (ram_count_q == DEPTH_CNT);

    dram_fifo_arb u_arb (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .flush_i        (flush_i),
        .wr_valid_i     (wr_valid_i),
        .full_i         (full),
        .ram_nonempty_i (ram_count_q != '0),
        .rd_valid_i     (rd_valid_q),
        .rd_ready_i     (rd_ready_i),
        .grant_o        (grant),
        .wr_ready_o     (wr_ready_o)
    );

    assign grant_wr = (grant == GNT_WR);
    assign grant_rd = (grant == GNT_RD);

    assign ram_addr_o = grant_rd ? rd_ptr_q : wr_ptr_q;
    assign ram_we_o   = grant_wr;
    assign ram_din_o  = wr_data_i;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_count_d = ram_count_q;
        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;
        if (flush_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            ram_count_d = '0;
            rd_valid_d  = 1'b0;
        end else begin
            // Grants are mutually exclusive, so the count moves by at most one.
            if (grant_wr) begin
                wr_ptr_d    = wr_ptr_q + PTR_ONE;
                ram_count_d = ram_count_q + CNT_ONE;
            end
            if (grant_rd) begin
                rd_ptr_d    = rd_ptr_q + PTR_ONE;
                ram_count_d = ram_count_q - CNT_ONE;
                rd_valid_d  = 1'b1;
                rd_data_d   = ram_dout_i;
            end else if (rd_valid_q && rd_ready_i) begin
                rd_valid_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_count_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_count_q <= ram_count_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign level_o    = ram_count_q + {{ADDR_WIDTH{1'b0}}, rd_valid_q};
    assign full_o     = full;
    assign empty_o    = (ram_count_q == '0) && !rd_valid_q;

endmodule : dram_fifo_sched
`default_nettype wire
